// File: rtl/div_pkg.sv
// div_pkg: shared widths and FSM state type for the 8-bit restoring divider
package div_pkg;
  localparam int DIV_W = 8;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step (rem, q_msb, divisor -> next_rem, q_bit) via ripple subtract
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W:0]   rem,
  input  logic             q_msb,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W:0]   next_rem,
  output logic             q_bit
);
  localparam int W = DIV_W + 2;
  logic [W-1:0] m, s, d, c;
  // rem[8] is always 0, so {rem, q_msb} equals the zero-extended shifted partial remainder
  assign m    = {rem, q_msb};
  assign s    = ~{2'b00, divisor};
  assign c[0] = 1'b1;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign d[i] = m[i] ^ s[i] ^ c[i];
    if (i < W - 1) begin : g_c
      assign c[i+1] = (m[i] & s[i]) | (c[i] & (m[i] ^ s[i]));
    end
  end
  assign q_bit    = ~d[W-1];
  assign next_rem = q_bit ? d[DIV_W:0] : m[DIV_W:0];
endmodule

// File: rtl/eight_bit_divider.sv
// eight_bit_divider: multi-cycle unsigned 8/8 restoring divider (run/busy/done handshake, div-by-zero flag)
module eight_bit_divider
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic fin, dz, q_bit;
  logic [DIV_W:0] rem, rem_nx;
  logic [DIV_W-1:0] q, dvsr;
  div_step u_step (
    .rem     (rem),
    .q_msb   (q[DIV_W-1]),
    .divisor (dvsr),
    .next_rem(rem_nx),
    .q_bit   (q_bit)
  );
  always_comb begin
    state_nx = state == IDLE ? (run ? (divisor == '0 ? DONE : CALC) : IDLE)
             : state == CALC ? (fin ? DONE : CALC)
             : (run ? DONE : IDLE);
    busy        = state == CALC;
    done        = state == DONE;
    div_by_zero = done & dz;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // fin marks that all 8 steps are complete; the following CALC edge publishes the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      fin       <= 1'b0;
      dz        <= 1'b0;
      rem       <= '0;
      q         <= '0;
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (state == IDLE && run) begin
      dvsr <= divisor;
      rem  <= '0;
      cnt  <= '0;
      fin  <= 1'b0;
      q    <= dividend;
      dz   <= divisor == '0;
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == CALC) begin
      if (fin) begin
        quotient  <= q;
        remainder <= rem[DIV_W-1:0];
      end else begin
        rem <= rem_nx;
        q   <= {q[DIV_W-2:0], q_bit};
        cnt <= cnt + 1'b1;
        fin <= cnt == '1;
      end
    end
  end
endmodule

// File: tb/tb_eight_bit_divider.sv
// tb_eight_bit_divider: directed and randomized checks of eight_bit_divider against an arithmetic model
module tb_eight_bit_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic [7:0] quotient, remainder;
  logic busy, done, div_by_zero;
  int checks = 0, failures = 0;
  int prev_q = 0, prev_r = 0;
  eight_bit_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input bit hold);
    int n, eq, er;
    eq = (b == 0) ? 255 : a / b;
    er = (b == 0) ? a : a % b;
    dividend = a;
    divisor  = b;
    run      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      run      = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
    end
    chk("busy_start", busy, b != 0);
    n = 0;
    while (!done && n < 20) begin
      if (n == 4) chk("hold_quot", quotient, prev_q);
      if (n == 4) chk("hold_rem", remainder, prev_r);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, (b == 0) ? 0 : 9);
    chk("quot", quotient, eq);
    chk("rem", remainder, er);
    chk("dbz", div_by_zero, b == 0);
    chk("busy_done", busy, 0);
    prev_q = eq;
    prev_r = er;
  endtask
  task automatic do_idle();
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done", done, 0);
    chk("idle_dbz", div_by_zero, 0);
    chk("retain_quot", quotient, prev_q);
    chk("retain_rem", remainder, prev_r);
  endtask
  initial begin
    logic [7:0] a, b;
    #2;
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_div(200, 7, 0);   do_idle();
    do_div(255, 1, 0);   do_idle();
    do_div(5, 9, 0);     do_idle();
    do_div(255, 255, 0); do_idle();
    do_div(100, 0, 0);   do_idle();
    do_div(0, 3, 0);     do_idle();
    do_div(200, 7, 1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done", done, 1);
      chk("hold_busy", busy, 0);
      chk("hold_q", quotient, 28);
    end
    do_idle();
    dividend = 200;
    divisor  = 7;
    run      = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_quot", quotient, 0);
    chk("mid_rst_rem", remainder, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    prev_q = 0;
    prev_r = 0;
    run = 1'b1;
    dividend = 9;
    divisor = 2;
    @(posedge clk);
    #1;
    chk("rst_held_busy", busy, 0);
    rst_n = 1'b1;
    do_div(9, 2, 0);
    do_idle();
    for (int i = 0; i < 2500; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      do_div(a, b, 0);
      do_idle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
